nbit_pc_rs: RTL and testbench

Parametrised program counter with a built-in return-address stack, for the sequencer front end. It extends the basic hold/load/increment counter in three ways: signed relative branch, subroutine CALL/RET through a LIFO of depth DEPTH, and a sticky error flag. All state updates on the rising edge of clk. The block feeds instruction-memory addressing and takes its op directly from the control unit.

---
 rtl/nbit_pc_pkg.sv | 24 ++
 rtl/nbit_pc_rs_ret_stack.sv | 48 ++++
 rtl/nbit_pc_rs.sv | 98 +++++++++
 tb/tb_nbit_pc_rs.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/nbit_pc_pkg.sv
// Shared op encodings for the sequencer program counter.
package nbit_pc_pkg;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_INC1   = 3'b010;
    localparam logic [2:0] OP_INCN   = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_CALL   = 3'b101;
    localparam logic [2:0] OP_RET    = 3'b110;
    localparam logic [2:0] OP_FLUSH  = 3'b111;

    typedef enum logic [2:0] {
        PC_HOLD   = OP_HOLD,
        PC_LOAD   = OP_LOAD,
        PC_INC1   = OP_INC1,
        PC_INCN   = OP_INCN,
        PC_BRANCH = OP_BRANCH,
        PC_CALL   = OP_CALL,
        PC_RET    = OP_RET,
        PC_FLUSH  = OP_FLUSH
    } pc_op_e;

endpackage

// File: rtl/nbit_pc_rs_ret_stack.sv
// Return-address LIFO with depth counter. Push when full and pop when empty
// are ignored; flush empties the stack without touching the storage.
module ret_stack #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [N-1:0]               din,
    output logic [N-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    import nbit_pc_pkg::*;

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = AW'(depth_q);
    assign rd_idx = AW'(depth_q - DW'(1));

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    // Top entry is meaningless while empty; callers never consume it then.
    assign top   = mem_q[rd_idx];

    // Storage write and depth counter update; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (flush) begin
            depth_q <= '0;
        end else if (push && !full) begin
            mem_q[wr_idx] <= din;
            depth_q       <= depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_q <= depth_q - DW'(1);
        end
    end

endmodule

// File: rtl/nbit_pc_rs.sv
// Program counter with relative branch, CALL/RET return stack and sticky
// overflow/underflow error flag. All arithmetic wraps modulo 2^N.
module nbit_pc_rs #(
    parameter int N     = 8,
    parameter int INC   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [2:0]                 op,
    input  logic [N-1:0]               pc_in,
    input  logic [N-1:0]               offset,
    output logic [N-1:0]               pc_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);
    import nbit_pc_pkg::*;

    localparam logic [N-1:0] INC_N = N'(INC);

    pc_op_e       op_s;
    logic [N-1:0] pc_q, pc_d;
    logic         err_q, err_d;
    logic         push, pop, flush_op;
    logic [N-1:0] stk_top;
    logic [N-1:0] ret_addr;

    assign op_s     = pc_op_e'(op);
    // Return address always skips exactly one slot, independent of INC.
    assign ret_addr = pc_q + N'(1);

    ret_stack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .push  (push),
        .pop   (pop),
        .flush (clr | flush_op),
        .din   (ret_addr),
        .top   (stk_top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // Next-pc mux, stack control and error-flag update.
    always_comb begin
        pc_d     = pc_q;
        err_d    = err_q;
        push     = 1'b0;
        pop      = 1'b0;
        flush_op = 1'b0;
        case (op_s)
            PC_HOLD:   pc_d = pc_q;
            PC_LOAD:   pc_d = pc_in;
            PC_INC1:   pc_d = pc_q + N'(1);
            PC_INCN:   pc_d = pc_q + INC_N;
            PC_BRANCH: pc_d = pc_q + offset;
            PC_CALL: begin
                // The jump is taken even when the push has to be dropped.
                pc_d = pc_in;
                if (full) err_d = 1'b1;
                else      push  = 1'b1;
            end
            PC_RET: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = stk_top;
                    pop  = 1'b1;
                end
            end
            PC_FLUSH: begin
                flush_op = 1'b1;
                err_d    = 1'b0;
            end
            default: pc_d = pc_q;
        endcase
    end

    // PC and error registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc_out = pc_q;
    assign err    = err_q;

endmodule

// File: tb/tb_nbit_pc_rs.sv
// Bench for nbit_pc_rs: directed scenarios with literal expectations plus
// random ops, all compared each cycle against a queue-based reference model.
module tb_nbit_pc_rs;

    localparam int N     = 8;
    localparam int INC   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [N-1:0]  pc_in = '0;
    logic [N-1:0]  offset = '0;
    logic [N-1:0]  pc_out;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pc = 0;
    int m_err = 0;
    int m_stk[$];
    bit m_valid = 1'b0;

    nbit_pc_rs #(.N(N), .INC(INC), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .clr    (clr),
        .op     (op),
        .pc_in  (pc_in),
        .offset (offset),
        .pc_out (pc_out),
        .depth  (depth),
        .full   (full),
        .empty  (empty),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each rising edge from the inputs held stable across it.
    always @(posedge clk) begin
        int so;
        if (clr) begin
            m_pc = 0;
            m_err = 0;
            m_stk.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (int'(op))
                0: ;
                1: m_pc = int'(pc_in);
                2: m_pc = (m_pc + 1) % 256;
                3: m_pc = (m_pc + INC) % 256;
                4: begin
                    so = (int'(offset) >= 128) ? int'(offset) - 256 : int'(offset);
                    m_pc = (m_pc + so + 256) % 256;
                end
                5: begin
                    if (m_stk.size() == DEPTH) m_err = 1;
                    else m_stk.push_back((m_pc + 1) % 256);
                    m_pc = int'(pc_in);
                end
                6: begin
                    if (m_stk.size() == 0) m_err = 1;
                    else m_pc = m_stk.pop_back();
                end
                default: begin
                    m_stk.delete();
                    m_err = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc_out", int'(pc_out), m_pc);
            chk("depth", int'(depth), m_stk.size());
            chk("full", int'(full), (m_stk.size() == DEPTH) ? 1 : 0);
            chk("empty", int'(empty), (m_stk.size() == 0) ? 1 : 0);
            chk("err", int'(err), m_err);
        end
    end

    task automatic step(input logic [2:0] o, input logic [7:0] p, input logic [7:0] f,
                        input logic c);
        op = o;
        pc_in = p;
        offset = f;
        clr = c;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input string name, input int exp_pc, input int exp_depth, input int exp_err);
        chk({name, "_pc"}, int'(pc_out), exp_pc);
        chk({name, "_depth"}, int'(depth), exp_depth);
        chk({name, "_err"}, int'(err), exp_err);
    endtask

    initial begin
        // Reset and basic counting
        step(3'd0, 8'h00, 8'h00, 1'b1);
        pin("reset", 0, 0, 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        step(3'd2, 8'h00, 8'h00, 1'b0); pin("inc1_a", 1, 0, 0);
        step(3'd2, 8'h00, 8'h00, 1'b0); pin("inc1_b", 2, 0, 0);
        step(3'd2, 8'h00, 8'h00, 1'b0); pin("inc1_c", 3, 0, 0);
        step(3'd3, 8'h00, 8'h00, 1'b0); pin("incn", 5, 0, 0);
        step(3'd1, 8'h40, 8'h00, 1'b0); pin("load", 8'h40, 0, 0);
        step(3'd0, 8'h00, 8'h00, 1'b0); pin("hold", 8'h40, 0, 0);

        // Wrap and signed branch
        step(3'd1, 8'hFE, 8'h00, 1'b0);
        step(3'd2, 8'h00, 8'h00, 1'b0); pin("wrap_a", 8'hFF, 0, 0);
        step(3'd2, 8'h00, 8'h00, 1'b0); pin("wrap_b", 8'h00, 0, 0);
        step(3'd4, 8'h00, 8'hFD, 1'b0); pin("br_neg", 8'hFD, 0, 0);
        step(3'd4, 8'h00, 8'h05, 1'b0); pin("br_pos", 8'h02, 0, 0);

        // Nested calls
        step(3'd1, 8'h10, 8'h00, 1'b0);
        step(3'd5, 8'h20, 8'h00, 1'b0); pin("call1", 8'h20, 1, 0);
        step(3'd5, 8'h30, 8'h00, 1'b0); pin("call2", 8'h30, 2, 0);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("ret2", 8'h21, 1, 0);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("ret1", 8'h11, 0, 0);

        // Overflow
        step(3'd1, 8'h00, 8'h00, 1'b0);
        step(3'd5, 8'h50, 8'h00, 1'b0);
        step(3'd5, 8'h60, 8'h00, 1'b0);
        step(3'd5, 8'h70, 8'h00, 1'b0);
        step(3'd5, 8'h78, 8'h00, 1'b0); pin("fill", 8'h78, 4, 0);
        chk("fill_full", int'(full), 1);
        step(3'd5, 8'h80, 8'h00, 1'b0); pin("ovf", 8'h80, 4, 1);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("pop4", 8'h71, 3, 1);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("pop3", 8'h61, 2, 1);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("pop2", 8'h51, 1, 1);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("pop1", 8'h01, 0, 1);

        // Underflow and flush
        step(3'd7, 8'h00, 8'h00, 1'b0); pin("flush0", 8'h01, 0, 0);
        step(3'd1, 8'h33, 8'h00, 1'b0);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("udf", 8'h33, 0, 1);
        step(3'd7, 8'h00, 8'h00, 1'b0); pin("flush", 8'h33, 0, 0);

        // Reset mid-operation
        step(3'd5, 8'h90, 8'h00, 1'b0);
        step(3'd5, 8'hA0, 8'h00, 1'b0);
        step(3'd5, 8'hB0, 8'h00, 1'b0); pin("pre_clr", 8'hB0, 3, 0);
        step(3'd5, 8'hC0, 8'h00, 1'b1); pin("mid_clr", 0, 0, 0);
        chk("mid_clr_empty", int'(empty), 1);
        step(3'd6, 8'h00, 8'h00, 1'b0); pin("clr_ret", 0, 0, 1);

        // Randomised traffic, with rare clears and a bias toward stack ops
        for (int i = 0; i < 600; i++) begin
            logic [2:0] ro;
            int sel;
            sel = int'($urandom_range(0, 11));
            ro = (sel >= 8) ? ((sel[0]) ? 3'd5 : 3'd6) : 3'(sel);
            step(ro, 8'($urandom), 8'($urandom), ($urandom_range(0, 40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
